// File: rtl/hazard_unit_sb.sv
// Scoreboarded hazard unit: mem/wrt forwarding, load-use stall, long-op RAW/WAW and capacity stalls, branch flush.
// Optional perf counters are built when the macro HAZARD_PERF_EN is defined.
module hazard_unit_sb #(
    parameter int REG_ADDR_W      = 5,
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32
) (
    input  logic                                   iclk,
    input  logic                                   irst_n,
    input  logic [REG_ADDR_W-1:0]                  irs1_decod,
    input  logic [REG_ADDR_W-1:0]                  irs2_decod,
    input  logic [REG_ADDR_W-1:0]                  ird_decod,
    input  logic                                   ilong_decod,
    input  logic [REG_ADDR_W-1:0]                  irs1_exect,
    input  logic [REG_ADDR_W-1:0]                  irs2_exect,
    input  logic [REG_ADDR_W-1:0]                  ird_exect,
    input  logic                                   ipc_src_exect,
    input  logic                                   iresult_src_b0_exect,
    input  logic                                   ilong_exect,
    input  logic [REG_ADDR_W-1:0]                  ird_mem,
    input  logic [REG_ADDR_W-1:0]                  ird_wrt,
    input  logic                                   ireg_wr_mem,
    input  logic                                   ireg_wr_wrt,
    input  logic                                   iwb_long_valid,
    input  logic [REG_ADDR_W-1:0]                  iwb_long_rd,
    output logic [1:0]                             oforward_ae,
    output logic [1:0]                             oforward_be,
    output logic                                   ostall_fetch,
    output logic                                   ostall_decod,
    output logic                                   oflush_decod,
    output logic                                   oflush_exect,
    output logic                                   obusy,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   ooutstanding
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]                       operf_stall_cycles,
    output logic [CNT_W-1:0]                       operf_flush_cycles,
    output logic [CNT_W-1:0]                       operf_sb_stall_cycles
`endif
);

    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [OUT_W-1:0]    count_q, count_d;
    logic                set, clr;
    logic                exect_src_match;
    logic                wlu, wsb, wcap, wle, wstall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_mem,
        input logic                  wr_mem,
        input logic [REG_ADDR_W-1:0] rd_wrt,
        input logic                  wr_wrt
    );
        if ((rs != '0) && wr_mem && (rs == rd_mem)) return 2'b10;
        if ((rs != '0) && wr_wrt && (rs == rd_wrt)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic reg_pending(
        input logic [NUM_REGS-1:0]   vec,
        input logic [REG_ADDR_W-1:0] r
    );
        return (r != '0) && (int'(r) < NUM_REGS) && vec[r];
    endfunction

    assign oforward_ae = fwd_sel(irs1_exect, ird_mem, ireg_wr_mem, ird_wrt, ireg_wr_wrt);
    assign oforward_be = fwd_sel(irs2_exect, ird_mem, ireg_wr_mem, ird_wrt, ireg_wr_wrt);

    assign set = ilong_exect && (ird_exect != '0) && (int'(ird_exect) < NUM_REGS);
    assign clr = iwb_long_valid && (iwb_long_rd != '0) && (int'(iwb_long_rd) < NUM_REGS);

    // NOTE: every variable written here gets a default first, otherwise the
    // untaken branches would infer latches.
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        if (clr) pending_d[iwb_long_rd] = 1'b0;
        // Set after clear so a same-cycle reissue to the same register keeps it pending.
        if (set) pending_d[ird_exect] = 1'b1;
        if (set && !clr && (count_q != MAX_CNT))
            count_d = count_q + 1'b1;
        else if (clr && !set && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    assign exect_src_match = (ird_exect != '0) &&
                             ((irs1_decod == ird_exect) || (irs2_decod == ird_exect));

    assign wlu  = iresult_src_b0_exect && exect_src_match;
    assign wsb  = reg_pending(pending_q, irs1_decod) ||
                  reg_pending(pending_q, irs2_decod) ||
                  reg_pending(pending_q, ird_decod);
    // Capacity looks at the next-state count so a completion this cycle frees a slot.
    assign wcap = ilong_decod && (count_d == MAX_CNT);
    // Pending is only set at the edge, so an issuing op in execute must be checked directly.
    assign wle  = ilong_exect && exect_src_match;
    assign wstall = wlu || wsb || wcap || wle;

    assign ostall_fetch = wstall && !ipc_src_exect;
    assign ostall_decod = wstall && !ipc_src_exect;
    assign oflush_decod = ipc_src_exect;
    assign oflush_exect = wstall || ipc_src_exect;

    assign obusy        = |pending_q;
    assign ooutstanding = count_q;

    // NOTE: the pending vector is ordinary flops, not a RAM, so it is reset
    // together with the count; obusy must read clean straight out of reset.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_stall_q, perf_flush_q, perf_sb_q;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_sb_q    <= '0;
        end else begin
            if (ostall_decod && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
            if (oflush_decod && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 1'b1;
            if ((wsb || wcap) && (perf_sb_q != '1))   perf_sb_q    <= perf_sb_q + 1'b1;
        end
    end

    assign operf_stall_cycles    = perf_stall_q;
    assign operf_flush_cycles    = perf_flush_q;
    assign operf_sb_stall_cycles = perf_sb_q;
`endif

    a_cfg: assert property (@(posedge iclk)
        (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING < NUM_REGS) && (CNT_W >= 1));

    a_clr_pending: assert property (@(posedge iclk) disable iff (!irst_n)
        clr |-> reg_pending(pending_q, iwb_long_rd));

    a_set_capacity: assert property (@(posedge iclk) disable iff (!irst_n)
        (set && !clr) |-> (count_q != MAX_CNT));

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Scoreboarded successor to the single-cycle hazard unit for the 5-stage RV pipeline. It adds tracking of variable-latency writers (multi-cycle loads, MUL/DIV), which complete through a dedicated long-latency writeback port.
- Per-register pending bits stall decode on RAW/WAW hazards against in-flight long ops.
- An outstanding-op counter enforces MAX_OUTSTANDING.
- Retains mem/wrt forwarding, single-cycle load-use stall and branch flush.
- Sits beside the pipeline registers; drives their stall/flush enables and the execute-stage forwarding muxes.

Parameters:
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, architectural registers tracked (2**REG_ADDR_W max); x0 never tracked.
- MAX_OUTSTANDING, 4, maximum simultaneously pending long ops (1..NUM_REGS-1).
- CNT_W, 32, perf counter width (used only with HAZARD_PERF_EN).

Ports:
- iclk  in  1  clock, rising edge.
- irst_n  in  1  asynchronous active-low reset.
- irs1_decod, irs2_decod, ird_decod  in  REG_ADDR_W  decode-stage source/dest registers.
- ilong_decod  in  1  decode instruction is a long-latency op.
- irs1_exect, irs2_exect, ird_exect  in  REG_ADDR_W  execute-stage registers.
- ipc_src_exect  in  1  taken branch/jump in execute.
- iresult_src_b0_exect  in  1  execute holds a single-cycle load.
- ilong_exect  in  1  execute holds a valid long op (issues to scoreboard this cycle).
- ird_mem, ird_wrt  in  REG_ADDR_W  mem/writeback destination registers.
- ireg_wr_mem, ireg_wr_wrt  in  1  mem/writeback register-write enables.
- iwb_long_valid  in  1  long op completes; its result is written to the register file at this edge.
- iwb_long_rd  in  REG_ADDR_W  destination of the completing long op.
- oforward_ae, oforward_be  out  2  forward select: 10 = mem, 01 = wrt, 00 = register file.
- ostall_fetch, ostall_decod, oflush_decod, oflush_exect  out  1  pipeline control.
- obusy  out  1  any register pending.
- ooutstanding  out  clog2(MAX_OUTSTANDING+1)  pending long-op count.

Behaviour:
- Reset (async, irst_n=0): pending[] = 0, count = 0, perf counters = 0; obusy=0, ooutstanding=0. Combinational outputs follow their inputs with the cleared state, so with no hazards all stalls/flushes are 0.
- Forwarding (combinational), per source:
  - mem when rs==ird_mem & ireg_wr_mem & rs!=0;
  - else wrt when rs==ird_wrt & ireg_wr_wrt & rs!=0;
  - else 00.
  - Mem has priority.
- Load-use stall: wlu = iresult_src_b0_exect & ird_exect!=0 & (irs1_decod==ird_exect | irs2_decod==ird_exect).
- Scoreboard stall: wsb = (pending[irs1_decod] & irs1_decod!=0) | (pending[irs2_decod] & irs2_decod!=0) | (pending[ird_decod] & ird_decod!=0).
- Capacity stall: wcap = ilong_decod & (count - clr + set) == MAX_OUTSTANDING. Evaluated on the next-state count, so a completion in the same cycle frees a slot.
- Execute-stage hazard: long-op issue with ird_exect matching a decode source also stalls (wle), since pending is set only at the edge.
- wstall = wlu | wsb | wcap | wle.
- Stall/flush outputs:
  - ostall_fetch = ostall_decod = wstall & ~ipc_src_exect (a branch overrides the stall).
  - oflush_decod = ipc_src_exect.
  - oflush_exect = wstall | ipc_src_exect.
- Scoreboard update each edge:
  - set = ilong_exect & ird_exect!=0 → pending[ird_exect] <= 1.
  - clr = iwb_long_valid & iwb_long_rd!=0 → pending[iwb_long_rd] <= 0.
  - Same register set and clear in one cycle: pending stays 1, count unchanged.
  - count <= count + set - clr.
- Dependent timing: dependents stall until the cycle after completion, then read the register file (write at completion edge). There is no long-writeback bypass; the penalty is 1 cycle.
- Error conditions (assertion only, no RTL recovery): clear of a non-pending register, or set when count==MAX_OUTSTANDING. Count saturates at 0 and MAX_OUTSTANDING.
- obusy = |pending; ooutstanding = count (registered).

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs operf_stall_cycles, operf_flush_cycles, operf_sb_stall_cycles (CNT_W each).
  - Increment respectively on ostall_decod, oflush_decod, and wsb|wcap.
  - Saturate at all-ones; reset to 0.
- Undefined: these ports and registers are absent.

Test Plan:
- Forwarding: irs1_exect=5, ird_mem=5, ird_wrt=5, both write enables=1 → oforward_ae=10. Set ireg_wr_mem=0 → 01. Set irs1_exect=0 → 00.
- Load-use: iresult_src_b0_exect=1, ird_exect=7, irs2_decod=7 → ostall_fetch/decod=1, oflush_exect=1 for one cycle. Add ipc_src_exect=1 → stalls 0, both flushes 1.
- Long RAW: issue ilong_exect with ird_exect=9. Next cycle irs1_decod=9 → stall until iwb_long_valid with rd=9; stall drops the following cycle; ooutstanding goes 1→0.
- Capacity: MAX_OUTSTANDING=4, issue rd=1..4, then ilong_decod=1 → wcap stall. Assert iwb_long_valid rd=2 in the same cycle → no stall.
- Simultaneous set/clear on rd=3 with pending[3]=1 → pending[3] stays 1, count unchanged. Assert irst_n low mid-operation → obusy=0 and ooutstanding=0 immediately (asynchronous).
